// File: rtl/router_pkt_sink.sv
// Router output-port packet sink: pulls one packet per start, checks its XOR parity,
// and abandons a packet whose bytes stop arriving for TIMEOUT consecutive cycles.
// state   | meaning
// IDLE    | waiting for vld_out while enable is high
// DELAY   | START_DELAY settle cycles before the first read
// HDR     | reading and capturing the header byte
// PAYLOAD | streaming len payload bytes out on byte_out
// PARITY  | comparing the parity byte, closes the packet
module router_pkt_sink #(
  parameter int START_DELAY = 2,
  parameter int TIMEOUT     = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       vld_out,
  input  logic [7:0] data_out,
  input  logic       enable,
  output logic       read_enb,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic [1:0] pkt_addr,
  output logic [5:0] pkt_len,
  output logic       pkt_done,
  output logic       parity_err,
  output logic       timeout,
  output logic [7:0] pkt_count,
  output logic [7:0] err_count
);

  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [4:0]    DLY_LOAD  = 5'((START_DELAY > 0) ? START_DELAY - 1 : 0);
  localparam logic [IW-1:0] IDLE_LOAD = IW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_DELAY, S_HDR, S_PAYLOAD, S_PARITY} state_t;

  state_t        state, state_nxt;
  logic [4:0]    dly_cnt;
  logic [IW-1:0] idle_cnt;
  logic [6:0]    issued;
  logic [6:0]    limit;
  logic [5:0]    remain;
  logic [7:0]    parity;
  logic          rd_pend;
  logic          active;
  logic          hit_timeout;
  logic          parity_bad;
  logic          err_inc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    active      = (state == S_HDR) || (state == S_PAYLOAD) || (state == S_PARITY);
    // Until the header is back the length is unknown, so allow the largest packet.
    limit       = (state == S_HDR) ? 7'd65 : ({1'b0, pkt_len} + 7'd2);
    read_enb    = active && vld_out && (issued < limit);
    hit_timeout = active && !rd_pend && (idle_cnt == '0);
    parity_bad  = (data_out != parity);
    err_inc     = hit_timeout || ((state == S_PARITY) && rd_pend && parity_bad);
    state_nxt   = state;
    case (state)
      S_IDLE:    if (vld_out && enable) state_nxt = (START_DELAY == 0) ? S_HDR : S_DELAY;
      S_DELAY:   if (dly_cnt == 5'd0) state_nxt = S_HDR;
      S_HDR:     if (rd_pend) state_nxt = (data_out[7:2] != 6'd0) ? S_PAYLOAD : S_PARITY;
      S_PAYLOAD: if (rd_pend && remain == 6'd1) state_nxt = S_PARITY;
      S_PARITY:  if (rd_pend) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    if (hit_timeout) state_nxt = S_IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dly_cnt    <= '0;
      idle_cnt   <= '0;
      issued     <= '0;
      remain     <= '0;
      parity     <= '0;
      rd_pend    <= 1'b0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      pkt_addr   <= '0;
      pkt_len    <= '0;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      timeout    <= 1'b0;
      pkt_count  <= '0;
      err_count  <= '0;
    end else begin
      byte_valid <= 1'b0;
      pkt_done   <= 1'b0;
      timeout    <= hit_timeout;
      rd_pend    <= read_enb;

      if (state == S_IDLE)                         dly_cnt <= DLY_LOAD;
      else if (state == S_DELAY && dly_cnt != '0)  dly_cnt <= dly_cnt - 5'd1;

      if (!active || rd_pend)   idle_cnt <= IDLE_LOAD;
      else if (idle_cnt != '0)  idle_cnt <= idle_cnt - 1'b1;

      if (state == S_IDLE) issued <= '0;
      else if (read_enb)   issued <= issued + 7'd1;

      if (rd_pend) begin
        case (state)
          S_HDR: begin
            pkt_addr <= data_out[1:0];
            pkt_len  <= data_out[7:2];
            remain   <= data_out[7:2];
            parity   <= data_out;
          end
          S_PAYLOAD: begin
            byte_out   <= data_out;
            byte_valid <= 1'b1;
            parity     <= parity ^ data_out;
            remain     <= remain - 6'd1;
          end
          S_PARITY: begin
            pkt_done   <= 1'b1;
            parity_err <= parity_bad;
            pkt_count  <= pkt_count + 8'd1;
          end
          default: ;
        endcase
      end

      if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_router_pkt_sink.sv
// Bench for router_pkt_sink: a router FIFO model feeds whole packets; results are
// compared against expectations built from the packet format itself.
module tb_router_pkt_sink;
  localparam int SD = 2;
  localparam int TO = 32;

  logic       clock = 1'b0;
  logic       reset, vld_out, enable;
  logic [7:0] data_out;
  logic       read_enb, byte_valid, pkt_done, parity_err, timeout;
  logic [7:0] byte_out, pkt_count, err_count;
  logic [1:0] pkt_addr;
  logic [5:0] pkt_len;

  router_pkt_sink #(.START_DELAY(SD), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .vld_out(vld_out), .data_out(data_out), .enable(enable),
    .read_enb(read_enb), .byte_out(byte_out), .byte_valid(byte_valid), .pkt_addr(pkt_addr),
    .pkt_len(pkt_len), .pkt_done(pkt_done), .parity_err(parity_err), .timeout(timeout),
    .pkt_count(pkt_count), .err_count(err_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo[$];
  logic       vld_gate, pend, prev_vld, rand_vld, rand_en;
  int         cycle, n_issued, last_ret, vld_rise;
  logic [7:0] got_bytes[$];
  logic       got_errs[$];
  int         done_cycles[$], issued_at_done[$], read_cycles[$], to_cycles[$];
  logic [7:0] exp_bytes[$];
  logic       exp_errs[$];
  logic [7:0] m_pkt_count, m_err_count;

  task automatic tick();
    @(posedge clock);
    #1;
    cycle++;
    if (pend && fifo.size() > 0) begin
      data_out = fifo.pop_front();
      last_ret = cycle;
    end
    pend = 1'b0;
    if (rand_en) enable = 1'($urandom_range(0, 1));
    vld_out = (fifo.size() > 0) && vld_gate && (!rand_vld || $urandom_range(0, 9) < 7);
    if (vld_out && !prev_vld) vld_rise = cycle;
    prev_vld = vld_out;
    @(negedge clock);
    if (read_enb && vld_out) begin
      pend = 1'b1;
      n_issued++;
      read_cycles.push_back(cycle);
    end
    if (byte_valid) got_bytes.push_back(byte_out);
    if (pkt_done) begin
      got_errs.push_back(parity_err);
      done_cycles.push_back(cycle);
      issued_at_done.push_back(n_issued);
    end
    if (timeout) to_cycles.push_back(cycle);
  endtask

  task automatic clear_rec();
    got_bytes.delete(); got_errs.delete(); done_cycles.delete(); issued_at_done.delete();
    read_cycles.delete(); to_cycles.delete(); exp_bytes.delete(); exp_errs.delete();
    n_issued = 0;
  endtask

  // Packet builder: header, len random bytes, XOR parity (optionally corrupted).
  task automatic send(input logic [5:0] len, input logic [1:0] addr, input logic corrupt);
    logic [7:0] hdr, p, b;
    hdr = {len, addr};
    p = hdr;
    fifo.push_back(hdr);
    for (int i = 0; i < int'(len); i++) begin
      b = 8'($urandom_range(1, 255));
      fifo.push_back(b);
      exp_bytes.push_back(b);
      p ^= b;
    end
    fifo.push_back(corrupt ? (p ^ 8'h01) : p);
    exp_errs.push_back(corrupt);
    m_pkt_count++;
    if (corrupt && m_err_count != 8'hFF) m_err_count++;
  endtask

  task automatic run(input int n, input int budget, output logic ok);
    int k;
    k = 0;
    while (done_cycles.size() < n && k < budget) begin
      tick();
      k++;
    end
    ok = (done_cycles.size() >= n);
  endtask

  task automatic test_reset();
    reset = 1'b1; vld_out = 1'b0; enable = 1'b0; data_out = 8'h00;
    vld_gate = 1'b0; pend = 1'b0; prev_vld = 1'b0; rand_vld = 1'b0; rand_en = 1'b0;
    cycle = 0; last_ret = 0; vld_rise = 0; m_pkt_count = 0; m_err_count = 0;
    clear_rec();
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({read_enb, byte_out, byte_valid, pkt_addr, pkt_len, pkt_done, parity_err, timeout,
         pkt_count, err_count} !== '0) begin
      errors++;
      $display("FAIL reset_values: got byte_out=%h pkt_count=%0d err_count=%0d rd=%b, expected all zero",
               byte_out, pkt_count, err_count, read_enb);
    end
    reset = 1'b0;
    repeat (4) tick();
    checks++;
    if (n_issued != 0 || read_enb !== 1'b0) begin
      errors++;
      $display("FAIL reset_quiet: got %0d reads, expected 0", n_issued);
    end
  endtask

  task automatic test_basic();
    logic ok;
    int mm;
    clear_rec();
    enable = 1'b1; vld_gate = 1'b1;
    send(6'd5, 2'd2, 1'b0);
    run(1, 300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_done: got no pkt_done, expected 1"); end
    checks++;
    if (n_issued != 7) begin errors++; $display("FAIL basic_reads: got %0d, expected 7", n_issued); end
    mm = 0;
    if (got_bytes.size() != exp_bytes.size()) mm = -1;
    else foreach (got_bytes[i]) if (got_bytes[i] !== exp_bytes[i]) mm++;
    checks++;
    if (mm != 0) begin
      errors++;
      $display("FAIL basic_payload: got %0d bytes (%0d wrong), expected %0d", got_bytes.size(), mm, exp_bytes.size());
    end
    checks++;
    if (got_errs.size() != 1 || got_errs[0] !== 1'b0) begin
      errors++; $display("FAIL basic_parity_err: got %0d strobes, expected one with parity_err 0", got_errs.size());
    end
    checks++;
    if (pkt_len !== 6'd5 || pkt_addr !== 2'd2) begin
      errors++; $display("FAIL basic_hdr: got len %0d addr %0d, expected len 5 addr 2", pkt_len, pkt_addr);
    end
    checks++;
    if (pkt_count !== m_pkt_count || err_count !== 8'd0) begin
      errors++; $display("FAIL basic_counts: got pkt %0d err %0d, expected pkt %0d err 0", pkt_count, err_count, m_pkt_count);
    end
    checks++;
    if (read_cycles.size() == 0 || read_cycles[0] - vld_rise != SD + 1) begin
      errors++; $display("FAIL basic_start_delay: got first read %0d cycles after vld, expected %0d",
                         (read_cycles.size() == 0) ? -1 : read_cycles[0] - vld_rise, SD + 1);
    end
    tick();
    checks++;
    if (done_cycles.size() != 1) begin
      errors++; $display("FAIL basic_done_width: got %0d pkt_done cycles, expected 1", done_cycles.size());
    end
  endtask

  task automatic test_parity_err();
    logic ok;
    clear_rec();
    send(6'd14, 2'd1, 1'b1);
    run(1, 300, ok);
    checks++;
    if (!ok || got_errs[0] !== 1'b1) begin
      errors++; $display("FAIL perr_flag: got done=%b, expected done with parity_err 1", ok);
    end
    checks++;
    if (err_count !== m_err_count || pkt_count !== m_pkt_count) begin
      errors++; $display("FAIL perr_counts: got err %0d pkt %0d, expected err %0d pkt %0d",
                         err_count, pkt_count, m_err_count, m_pkt_count);
    end
    repeat (5) tick();
    checks++;
    if (parity_err !== 1'b1 || pkt_len !== 6'd14 || pkt_addr !== 2'd1) begin
      errors++; $display("FAIL perr_hold: got perr %b len %0d addr %0d, expected 1 14 1", parity_err, pkt_len, pkt_addr);
    end
  endtask

  task automatic test_zero_len();
    logic ok;
    clear_rec();
    send(6'd0, 2'd0, 1'b0);
    run(1, 200, ok);
    checks++;
    if (!ok || n_issued != 2 || got_bytes.size() != 0) begin
      errors++; $display("FAIL zero_len: got done=%b reads %0d bytes %0d, expected done reads 2 bytes 0",
                         ok, n_issued, got_bytes.size());
    end
    checks++;
    if (parity_err !== 1'b0 || pkt_len !== 6'd0) begin
      errors++; $display("FAIL zero_len_flags: got perr %b len %0d, expected 0 0", parity_err, pkt_len);
    end
  endtask

  task automatic test_back_to_back();
    logic ok;
    int mm;
    clear_rec();
    send(6'd16, 2'd0, 1'b0);
    send(6'd5, 2'd3, 1'b0);
    run(2, 500, ok);
    checks++;
    if (!ok || issued_at_done[0] != 18 || issued_at_done[1] != 25) begin
      errors++; $display("FAIL b2b_reads: got done=%b, reads at first done %0d, expected 18 then 25",
                         ok, (issued_at_done.size() > 0) ? issued_at_done[0] : -1);
    end
    checks++;
    if (read_cycles.size() < 19 || done_cycles.size() < 1 || read_cycles[18] - done_cycles[0] != SD + 1) begin
      errors++; $display("FAIL b2b_restart_delay: got %0d reads, expected second header read %0d cycles after done",
                         read_cycles.size(), SD + 1);
    end
    mm = 0;
    if (got_bytes.size() != exp_bytes.size()) mm = -1;
    else foreach (got_bytes[i]) if (got_bytes[i] !== exp_bytes[i]) mm++;
    checks++;
    if (mm != 0 || pkt_count !== m_pkt_count) begin
      errors++; $display("FAIL b2b_data: got %0d bytes (%0d wrong) pkt %0d, expected %0d bytes pkt %0d",
                         got_bytes.size(), mm, pkt_count, exp_bytes.size(), m_pkt_count);
    end
  endtask

  task automatic test_timeout();
    logic ok;
    int k;
    clear_rec();
    fifo.push_back({6'd14, 2'd1});
    repeat (3) fifo.push_back(8'($urandom_range(1, 255)));
    if (m_err_count != 8'hFF) m_err_count++;
    k = 0;
    while (to_cycles.size() == 0 && k < 200) begin tick(); k++; end
    checks++;
    if (to_cycles.size() == 0 || to_cycles[0] != last_ret + TO + 1) begin
      errors++; $display("FAIL timeout_cycle: got strobe at %0d, expected %0d",
                         (to_cycles.size() > 0) ? to_cycles[0] : -1, last_ret + TO + 1);
    end
    checks++;
    if (n_issued != 4 || got_bytes.size() != 3 || done_cycles.size() != 0 || read_enb !== 1'b0) begin
      errors++; $display("FAIL timeout_reads: got reads %0d bytes %0d dones %0d rd %b, expected 4 3 0 0",
                         n_issued, got_bytes.size(), done_cycles.size(), read_enb);
    end
    repeat (3) tick();
    checks++;
    if (to_cycles.size() != 1 || err_count !== m_err_count) begin
      errors++; $display("FAIL timeout_strobe: got %0d strobes err %0d, expected 1 strobe err %0d",
                         to_cycles.size(), err_count, m_err_count);
    end
    clear_rec();
    send(6'd3, 2'd2, 1'b0);
    run(1, 200, ok);
    checks++;
    if (!ok || got_errs[0] !== 1'b0 || pkt_len !== 6'd3 || read_cycles[0] - vld_rise != SD + 1) begin
      errors++; $display("FAIL timeout_recover: got done=%b len %0d, expected clean len 3 packet after fresh delay", ok, pkt_len);
    end
  endtask

  task automatic test_enable();
    logic ok;
    int k;
    clear_rec();
    enable = 1'b0;
    send(6'd4, 2'd1, 1'b0);
    repeat (20) tick();
    checks++;
    if (n_issued != 0) begin errors++; $display("FAIL enable_gate: got %0d reads, expected 0", n_issued); end
    enable = 1'b1;
    k = 0;
    while (n_issued < 2 && k < 50) begin tick(); k++; end
    enable = 1'b0;
    run(1, 200, ok);
    checks++;
    if (!ok || got_bytes.size() != 4 || got_errs[0] !== 1'b0) begin
      errors++; $display("FAIL enable_mid: got done=%b bytes %0d, expected completed packet of 4", ok, got_bytes.size());
    end
    enable = 1'b1;
  endtask

  task automatic test_random();
    logic ok;
    int mm, total;
    clear_rec();
    total = 0;
    rand_vld = 1'b1; rand_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      logic [5:0] len;
      len = 6'($urandom_range(0, 63));
      total += int'(len) + 2;
      send(len, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
    end
    run(12, 5000, ok);
    rand_vld = 1'b0; rand_en = 1'b0; enable = 1'b1;
    checks++;
    if (!ok) begin errors++; $display("FAIL random_done: got %0d packets, expected 12", done_cycles.size()); end
    mm = 0;
    if (got_bytes.size() != exp_bytes.size()) mm = -1;
    else foreach (got_bytes[i]) if (got_bytes[i] !== exp_bytes[i]) mm++;
    checks++;
    if (mm != 0) begin
      errors++; $display("FAIL random_payload: got %0d bytes (%0d wrong), expected %0d", got_bytes.size(), mm, exp_bytes.size());
    end
    mm = 0;
    if (got_errs.size() != exp_errs.size()) mm = -1;
    else foreach (got_errs[i]) if (got_errs[i] !== exp_errs[i]) mm++;
    checks++;
    if (mm != 0 || n_issued != total) begin
      errors++; $display("FAIL random_parity: got %0d flags wrong, %0d reads, expected 0 wrong, %0d reads", mm, n_issued, total);
    end
    checks++;
    if (pkt_count !== m_pkt_count || err_count !== m_err_count) begin
      errors++; $display("FAIL random_counts: got pkt %0d err %0d, expected pkt %0d err %0d",
                         pkt_count, err_count, m_pkt_count, m_err_count);
    end
  endtask

  task automatic test_reset_mid();
    logic ok;
    int k, mm;
    clear_rec();
    send(6'd10, 2'd3, 1'b0);
    k = 0;
    while (got_bytes.size() < 4 && k < 200) begin tick(); k++; end
    checks++;
    if (got_bytes.size() < 4) begin errors++; $display("FAIL rstmid_progress: got %0d bytes, expected 4", got_bytes.size()); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({read_enb, byte_out, byte_valid, pkt_addr, pkt_len, pkt_done, parity_err, timeout,
         pkt_count, err_count} !== '0) begin
      errors++; $display("FAIL rstmid_values: got byte_out=%h pkt_count=%0d rd=%b, expected all zero",
                         byte_out, pkt_count, read_enb);
    end
    pend = 1'b0; fifo.delete(); vld_out = 1'b0; prev_vld = 1'b0;
    m_pkt_count = 0; m_err_count = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    clear_rec();
    send(6'd6, 2'd1, 1'b0);
    run(1, 200, ok);
    mm = 0;
    if (got_bytes.size() != exp_bytes.size()) mm = -1;
    else foreach (got_bytes[i]) if (got_bytes[i] !== exp_bytes[i]) mm++;
    checks++;
    if (!ok || mm != 0 || pkt_count !== 8'd1 || err_count !== 8'd0 || pkt_len !== 6'd6 || pkt_addr !== 2'd1) begin
      errors++; $display("FAIL rstmid_next: got done=%b wrong %0d pkt %0d len %0d, expected clean packet pkt 1 len 6",
                         ok, mm, pkt_count, pkt_len);
    end
  endtask

  task automatic test_wrap();
    logic ok;
    int mm;
    clear_rec();
    for (int i = 0; i < 262; i++) send(6'd0, 2'($urandom_range(0, 3)), (i % 64) != 0);
    run(262, 8000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_done: got %0d packets, expected 262", done_cycles.size()); end
    mm = 0;
    if (got_errs.size() != exp_errs.size()) mm = -1;
    else foreach (got_errs[i]) if (got_errs[i] !== exp_errs[i]) mm++;
    checks++;
    if (mm != 0) begin errors++; $display("FAIL wrap_flags: got %0d wrong parity flags, expected 0", mm); end
    checks++;
    if (pkt_count !== m_pkt_count || err_count !== 8'hFF) begin
      errors++; $display("FAIL wrap_counts: got pkt %0d err %0d, expected pkt %0d err 255", pkt_count, err_count, m_pkt_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_zero_len();
    test_back_to_back();
    test_timeout();
    test_enable();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
